outer_ebi_trx: RTL and testbench
================================

# outer_ebi_trx

Off-chip-side EBI transceiver: the responder at the far end of the EBI link driven by the on-chip cache EBI transceiver. It deserialises host frames (read request, write requests, snoop responses) into a parallel request for the memory/coherence model. It serialises read responses, snoop requests and acknowledges back onto the shared bidirectional EBI bus. The block has a self-contained FSM, so no external sequencing controls are needed.

## Interface
- `DATA_WIDTH`, 64: backend word width (informational, unused in datapath).
- `PADDR_WIDTH`, 32: physical address width; `ADDR_CYCLE = PADDR_WIDTH/EBI_WIDTH`.
- `CACHELINE_LENGTH`, 512: line width; `DATA_CYCLE = CACHELINE_LENGTH/EBI_WIDTH`.
- `EBI_WIDTH`, 16: bus width; ≥ 4.
- `clk` in 1: single clock; every register, including the bus-drive registers, updates on its rising edge.
- `rst` in 1: reset; **synchronous, active-high**.
- `ebi_i` in EBI_WIDTH: bus pins, input.
- `ebi_o` out EBI_WIDTH: bus pins, output value.
- `ebi_oen` out EBI_WIDTH: output enable, active-low, all bits equal.
- `req_valid` out 1, `req_ready` in 1: decoded host request handshake.
- `req_opcode` out 4: 0 DR, 1 DW1, 2 DW2, 3 SNP_RESP1, 4 SNP_RESP2.
- `req_addr` out PADDR_WIDTH, `req_snoop` out EBI_WIDTH, `req_id` out EBI_WIDTH, `req_data` out CACHELINE_LENGTH: request fields.
- `rd_resp_valid` in 1, `rd_resp_ready` out 1: read-response handshake.
- `rd_resp_data` in CACHELINE_LENGTH, `rd_resp_mesi` in EBI_WIDTH, `rd_resp_id` in EBI_WIDTH: read-response fields.
- `snp_req_valid` in 1, `snp_req_ready` out 1: snoop-request handshake.
- `snp_req_addr` in PADDR_WIDTH, `snp_req_snoop` in EBI_WIDTH: snoop-request fields.
- `frame_err` out 1: one-cycle pulse when a host frame is dropped.

## Operation
- Bus encoding:
  - Idle/stop beat is all-ones.
  - Start beat is all-ones with bit0=0 (16'hFFFE).
  - Opcode beat is `{zeros, opcode[3:0]}`.
  - Multi-beat fields are sent low beat first.
  - A receiver reads an ACK frame (start, stop) as opcode 4'hF.
- Host frames, payload after the opcode beat, then one stop beat:
  - DR: addr(ADDR_CYCLE), snoop(1), id(1).
  - DW1: addr, snoop, data(DATA_CYCLE).
  - DW2: addr, snoop.
  - SNP_RESP1: data.
  - SNP_RESP2: none.
- Frames sent by this block:
  - RD_RESP (opcode 7): start, opcode, data, mesi, id, stop = 37 beats.
  - SNP_REQ (opcode 6): start, opcode, addr, snoop, stop = 6 beats.
  - ACK: start, stop = 2 beats.
- Input path: `ebi_i` passes through one register, `rff`. All decode uses `rff`.
- FSM states and transitions:
  - IDLE: `ebi_oen` all ones.
    - `rff[0]==0` → RX_OP.
    - Else, if `snp_req_valid`: pulse `snp_req_ready`, latch the SNP_REQ frame, go to TX.
    - A host start seen in the same cycle wins; the snoop waits.
  - RX_OP: latch `rff[3:0]` and load the payload counter.
    - Opcodes 0–4 → RX_PAYLOAD, or RX_STOP if the payload is empty.
    - Any other opcode → pulse `frame_err` → IDLE.
  - RX_PAYLOAD: store `rff` into the receive buffer at the beat index, low to high. After the last payload beat → RX_STOP.
  - RX_STOP: `rff` must be all-ones.
    - If it is: register the fields into the `req_*` outputs → DELIVER.
    - If not: pulse `frame_err`, drop the frame → IDLE.
  - DELIVER: `req_valid`=1; all `req_*` fields are held stable until `req_ready`.
    - On the handshake with DR → WAIT_RESP.
    - On the handshake with any other opcode → TX with an ACK frame.
    - Fields not carried by the opcode read as 0.
  - WAIT_RESP: `rd_resp_ready`=1. On `rd_resp_valid`, latch the RD_RESP frame → TX.
  - TX:
    - Every beat, including the stop beat, is driven with `ebi_oen` all zeros.
    - The beat counter (6-bit) runs 0..len-1.
    - After the stop beat → IDLE, where `ebi_oen` is all ones.
- `ebi_o` is all-ones whenever the block is not in TX.
- Request fields are not cleared between frames, apart from the zero rule for unused fields.

## Timing
- Reset values:
  - `ebi_oen` = `ebi_o` = all ones.
  - `req_valid` = `rd_resp_ready` = `snp_req_ready` = `frame_err` = 0.
  - All `req_*` fields = 0; state IDLE.
- Receive timing:
  - Host start beat on `ebi_i` in cycle t → RX_OP at t+2.
  - Stop beat on `ebi_i` in cycle s → `req_valid` high from s+2.
- Transmit timing:
  - Handshake in cycle c (`req`, `rd_resp` or `snp_req`) → start beat on `ebi_o` with oen=0 at c+1.
  - Stop beat at c+len.
  - oen returns to all ones at c+len+1.
- Ready/valid: a transfer occurs when both are high at a rising edge. `rd_resp_ready` and `snp_req_ready` are purely state-derived.
- Reset asserted mid-frame (RX or TX) → IDLE, with outputs at reset values after that edge.
- `frame_err` is a one-cycle pulse, aligned to the cycle after the offending beat is in `rff`.

## Test plan
1. DR request:
   - Host sends FFFE,0000,1234,8000,0003,0005,FFFF → `req_valid` with opcode 0, addr 0x80001234, snoop 3, id 5.
   - Backend returns data beats 0x0000..0x001F, mesi 2, id 5 → `ebi_o` = FFFE,0007,0000..001F,0002,0005,FFFF with oen=0 for exactly 37 cycles.
2. DW1 request:
   - Host sends DW1 with addr 0x100, snoop 0, data beats 0xA000+i → `req_data[16i+:16]`=0xA000+i.
   - After `req_ready`, ACK FFFE,FFFF is driven with oen=0 for 2 cycles.
3. Snoop request:
   - From idle, `snp_req_valid` with addr 0xDEAD0040, snoop 1 → FFFE,0006,0040,DEAD,0001,FFFF.
   - Repeat with a host start arriving in the same cycle → the host frame is received first, and the snoop is sent after the host transaction completes.
4. Bad frames:
   - Opcode 5 → one `frame_err` pulse, no `req_valid`, block back in IDLE.
   - DW2 with stop beat 0x1234 → one `frame_err` pulse, no `req_valid`, block back in IDLE.
5. Backpressure: `req_ready` held low for 10 cycles → `req_valid` and all fields stay stable; ACK starts the cycle after `req_ready`.
6. Reset mid-TX: `rst` pulsed at RD_RESP beat 10 → `ebi_oen`=FFFF, `ebi_o`=FFFF next cycle; the next host DR is then received correctly.

Source files
------------

// File: rtl/outer_ebi_trx.sv
// outer_ebi_trx: far-end responder on the EBI link. Deserialises host frames
// (read/write requests, snoop responses) into one parallel request, and
// serialises read responses, snoop requests and ACKs back onto the shared bus.
module outer_ebi_trx #(
  parameter int DATA_WIDTH       = 64,
  parameter int PADDR_WIDTH      = 32,
  parameter int CACHELINE_LENGTH = 512,
  parameter int EBI_WIDTH        = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [EBI_WIDTH-1:0]        ebi_i,
  output logic [EBI_WIDTH-1:0]        ebi_o,
  output logic [EBI_WIDTH-1:0]        ebi_oen,
  output logic                        req_valid,
  input  logic                        req_ready,
  output logic [3:0]                  req_opcode,
  output logic [PADDR_WIDTH-1:0]      req_addr,
  output logic [EBI_WIDTH-1:0]        req_snoop,
  output logic [EBI_WIDTH-1:0]        req_id,
  output logic [CACHELINE_LENGTH-1:0] req_data,
  input  logic                        rd_resp_valid,
  output logic                        rd_resp_ready,
  input  logic [CACHELINE_LENGTH-1:0] rd_resp_data,
  input  logic [EBI_WIDTH-1:0]        rd_resp_mesi,
  input  logic [EBI_WIDTH-1:0]        rd_resp_id,
  input  logic                        snp_req_valid,
  output logic                        snp_req_ready,
  input  logic [PADDR_WIDTH-1:0]      snp_req_addr,
  input  logic [EBI_WIDTH-1:0]        snp_req_snoop,
  output logic                        frame_err
);

  localparam int ADDR_CYCLE = PADDR_WIDTH / EBI_WIDTH;
  localparam int DATA_CYCLE = CACHELINE_LENGTH / EBI_WIDTH;
  // Longest host payload is DW1: addr + snoop + data.
  localparam int RX_MAX     = ADDR_CYCLE + 1 + DATA_CYCLE;
  localparam int RD_LEN     = DATA_CYCLE + 5;
  localparam int SNP_LEN    = ADDR_CYCLE + 4;
  localparam int ACK_LEN    = 2;
  localparam int TX_MAX     = (RD_LEN > SNP_LEN) ? RD_LEN : SNP_LEN;
  localparam int CW         = 6;

  localparam logic [EBI_WIDTH-1:0] BEAT_IDLE  = {EBI_WIDTH{1'b1}};
  localparam logic [EBI_WIDTH-1:0] BEAT_START = {{(EBI_WIDTH-1){1'b1}}, 1'b0};

  localparam logic [3:0] OP_DR        = 4'd0;
  localparam logic [3:0] OP_DW1       = 4'd1;
  localparam logic [3:0] OP_DW2       = 4'd2;
  localparam logic [3:0] OP_SNP_RESP1 = 4'd3;
  localparam logic [3:0] OP_SNP_RESP2 = 4'd4;
  localparam logic [3:0] OP_SNP_REQ   = 4'd6;
  localparam logic [3:0] OP_RD_RESP   = 4'd7;

  // The backend word width does not shape the datapath; reject nonsense values early.
  if (EBI_WIDTH < 4 || DATA_WIDTH < EBI_WIDTH) begin : g_param_check
    $error("outer_ebi_trx: EBI_WIDTH must be >= 4 and <= DATA_WIDTH");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_RX_OP,
    S_RX_PAYLOAD,
    S_RX_STOP,
    S_DELIVER,
    S_WAIT_RESP,
    S_TX
  } state_t;

  typedef enum logic [1:0] {
    TX_NONE,
    TX_ACK,
    TX_SNP,
    TX_RD
  } tx_kind_t;

  state_t                state_reg, state_next;
  tx_kind_t              tx_load;
  logic                  rx_op_load;
  logic                  rx_store;
  logic                  req_load;
  logic                  err_next;
  logic                  tx_last;

  logic [EBI_WIDTH-1:0]  rff_reg;
  logic [3:0]            op_reg;
  logic [CW-1:0]         rx_len_reg;
  logic [CW-1:0]         rx_cnt_reg;
  logic [EBI_WIDTH-1:0]  rx_buf_reg [RX_MAX];

  logic [EBI_WIDTH-1:0]  tx_buf_reg [TX_MAX];
  logic [CW-1:0]         tx_len_reg;
  logic [CW-1:0]         tx_cnt_reg;

  logic [EBI_WIDTH-1:0]  ebi_o_reg;
  logic [EBI_WIDTH-1:0]  ebi_oen_reg;
  logic [3:0]            req_opcode_reg;
  logic [PADDR_WIDTH-1:0] req_addr_reg;
  logic [EBI_WIDTH-1:0]  req_snoop_reg;
  logic [EBI_WIDTH-1:0]  req_id_reg;
  logic [CACHELINE_LENGTH-1:0] req_data_reg;
  logic                  frame_err_reg;
  logic                  snp_ready_reg;

  logic [PADDR_WIDTH-1:0]      rx_addr;
  logic [CACHELINE_LENGTH-1:0] rx_dw1_data;
  logic [CACHELINE_LENGTH-1:0] rx_sr1_data;

  logic [EBI_WIDTH-1:0]  frm_rd  [TX_MAX];
  logic [EBI_WIDTH-1:0]  frm_snp [TX_MAX];
  logic [EBI_WIDTH-1:0]  frm_ack [TX_MAX];

  // Number of payload beats between the opcode beat and the stop beat.
  function automatic logic [CW-1:0] payload_len(input logic [3:0] op);
    case (op)
      OP_DR:        return CW'(ADDR_CYCLE + 2);
      OP_DW1:       return CW'(ADDR_CYCLE + 1 + DATA_CYCLE);
      OP_DW2:       return CW'(ADDR_CYCLE + 1);
      OP_SNP_RESP1: return CW'(DATA_CYCLE);
      default:      return '0;
    endcase
  endfunction

  // Field views of the receive buffer; payload is stored low beat first.
  for (genvar gi = 0; gi < ADDR_CYCLE; gi++) begin : g_rx_addr
    assign rx_addr[gi*EBI_WIDTH +: EBI_WIDTH] = rx_buf_reg[gi];
  end
  for (genvar gi = 0; gi < DATA_CYCLE; gi++) begin : g_rx_data
    assign rx_dw1_data[gi*EBI_WIDTH +: EBI_WIDTH] = rx_buf_reg[ADDR_CYCLE + 1 + gi];
    assign rx_sr1_data[gi*EBI_WIDTH +: EBI_WIDTH] = rx_buf_reg[gi];
  end

  // Candidate outgoing frames, beat by beat, padded with idle beats.
  for (genvar gi = 0; gi < TX_MAX; gi++) begin : g_frames
    if (gi == 0) begin : g_start
      assign frm_rd[gi]  = BEAT_START;
      assign frm_snp[gi] = BEAT_START;
      assign frm_ack[gi] = BEAT_START;
    end else if (gi == 1) begin : g_op
      assign frm_rd[gi]  = {{(EBI_WIDTH-4){1'b0}}, OP_RD_RESP};
      assign frm_snp[gi] = {{(EBI_WIDTH-4){1'b0}}, OP_SNP_REQ};
      assign frm_ack[gi] = BEAT_IDLE;
    end else begin : g_body
      assign frm_ack[gi] = BEAT_IDLE;
      if (gi < 2 + DATA_CYCLE) begin : g_rd_data
        assign frm_rd[gi] = rd_resp_data[(gi-2)*EBI_WIDTH +: EBI_WIDTH];
      end else if (gi == 2 + DATA_CYCLE) begin : g_rd_mesi
        assign frm_rd[gi] = rd_resp_mesi;
      end else if (gi == 3 + DATA_CYCLE) begin : g_rd_id
        assign frm_rd[gi] = rd_resp_id;
      end else begin : g_rd_stop
        assign frm_rd[gi] = BEAT_IDLE;
      end
      if (gi < 2 + ADDR_CYCLE) begin : g_snp_addr
        assign frm_snp[gi] = snp_req_addr[(gi-2)*EBI_WIDTH +: EBI_WIDTH];
      end else if (gi == 2 + ADDR_CYCLE) begin : g_snp_snoop
        assign frm_snp[gi] = snp_req_snoop;
      end else begin : g_snp_stop
        assign frm_snp[gi] = BEAT_IDLE;
      end
    end
  end

  assign tx_last = (tx_cnt_reg == tx_len_reg - CW'(1));

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic and per-cycle datapath controls.
  always_comb begin
    state_next = state_reg;
    tx_load    = TX_NONE;
    rx_op_load = 1'b0;
    rx_store   = 1'b0;
    req_load   = 1'b0;
    err_next   = 1'b0;
    unique case (state_reg)
      S_IDLE: begin
        // A host start already in rff takes priority over a pending snoop.
        if (!rff_reg[0]) begin
          state_next = S_RX_OP;
        end else if (snp_req_valid && snp_ready_reg) begin
          tx_load    = TX_SNP;
          state_next = S_TX;
        end
      end
      S_RX_OP: begin
        rx_op_load = 1'b1;
        if (rff_reg[3:0] > OP_SNP_RESP2) begin
          err_next   = 1'b1;
          state_next = S_IDLE;
        end else if (payload_len(rff_reg[3:0]) == '0) begin
          state_next = S_RX_STOP;
        end else begin
          state_next = S_RX_PAYLOAD;
        end
      end
      S_RX_PAYLOAD: begin
        rx_store = 1'b1;
        if (rx_cnt_reg == rx_len_reg - CW'(1)) begin
          state_next = S_RX_STOP;
        end
      end
      S_RX_STOP: begin
        if (rff_reg == BEAT_IDLE) begin
          req_load   = 1'b1;
          state_next = S_DELIVER;
        end else begin
          err_next   = 1'b1;
          state_next = S_IDLE;
        end
      end
      S_DELIVER: begin
        if (req_ready) begin
          if (req_opcode_reg == OP_DR) begin
            state_next = S_WAIT_RESP;
          end else begin
            tx_load    = TX_ACK;
            state_next = S_TX;
          end
        end
      end
      S_WAIT_RESP: begin
        if (rd_resp_valid) begin
          tx_load    = TX_RD;
          state_next = S_TX;
        end
      end
      S_TX: begin
        if (tx_last) begin
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Input register and receive buffer fill.
  always_ff @(posedge clk) begin
    if (rst) begin
      rff_reg    <= BEAT_IDLE;
      op_reg     <= '0;
      rx_len_reg <= '0;
      rx_cnt_reg <= '0;
    end else begin
      rff_reg <= ebi_i;
      if (rx_op_load) begin
        op_reg     <= rff_reg[3:0];
        rx_len_reg <= payload_len(rff_reg[3:0]);
        rx_cnt_reg <= '0;
      end
      if (rx_store) begin
        rx_buf_reg[rx_cnt_reg] <= rff_reg;
        rx_cnt_reg             <= rx_cnt_reg + CW'(1);
      end
    end
  end

  // Request fields: loaded on a good stop beat, zero where the opcode carries nothing.
  always_ff @(posedge clk) begin
    if (rst) begin
      req_opcode_reg <= '0;
      req_addr_reg   <= '0;
      req_snoop_reg  <= '0;
      req_id_reg     <= '0;
      req_data_reg   <= '0;
    end else if (req_load) begin
      req_opcode_reg <= op_reg;
      req_addr_reg   <= (op_reg <= OP_DW2) ? rx_addr : '0;
      req_snoop_reg  <= (op_reg <= OP_DW2) ? rx_buf_reg[ADDR_CYCLE] : '0;
      req_id_reg     <= (op_reg == OP_DR) ? rx_buf_reg[ADDR_CYCLE + 1] : '0;
      if (op_reg == OP_DW1) begin
        req_data_reg <= rx_dw1_data;
      end else if (op_reg == OP_SNP_RESP1) begin
        req_data_reg <= rx_sr1_data;
      end else begin
        req_data_reg <= '0;
      end
    end
  end

  // Transmit buffer capture and beat counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_len_reg <= '0;
      tx_cnt_reg <= '0;
    end else if (tx_load != TX_NONE) begin
      for (int i = 0; i < TX_MAX; i++) begin
        case (tx_load)
          TX_RD:   tx_buf_reg[i] <= frm_rd[i];
          TX_SNP:  tx_buf_reg[i] <= frm_snp[i];
          default: tx_buf_reg[i] <= frm_ack[i];
        endcase
      end
      case (tx_load)
        TX_RD:   tx_len_reg <= CW'(RD_LEN);
        TX_SNP:  tx_len_reg <= CW'(SNP_LEN);
        default: tx_len_reg <= CW'(ACK_LEN);
      endcase
      tx_cnt_reg <= '0;
    end else if (state_reg == S_TX && !tx_last) begin
      tx_cnt_reg <= tx_cnt_reg + CW'(1);
    end
  end

  // Bus drive: start beat straight from the handshake, then the buffered beats.
  always_ff @(posedge clk) begin
    if (rst) begin
      ebi_o_reg   <= BEAT_IDLE;
      ebi_oen_reg <= '1;
    end else if (tx_load != TX_NONE) begin
      ebi_o_reg   <= BEAT_START;
      ebi_oen_reg <= '0;
    end else if (state_reg == S_TX && !tx_last) begin
      ebi_o_reg   <= tx_buf_reg[tx_cnt_reg + CW'(1)];
      ebi_oen_reg <= '0;
    end else begin
      ebi_o_reg   <= BEAT_IDLE;
      ebi_oen_reg <= '1;
    end
  end

  // Error pulse and snoop-ready: ready mirrors "idle with no host start in rff".
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_err_reg <= 1'b0;
      snp_ready_reg <= 1'b0;
    end else begin
      frame_err_reg <= err_next;
      snp_ready_reg <= (state_next == S_IDLE) && ebi_i[0];
    end
  end

  assign ebi_o         = ebi_o_reg;
  assign ebi_oen       = ebi_oen_reg;
  assign req_valid     = (state_reg == S_DELIVER);
  assign rd_resp_ready = (state_reg == S_WAIT_RESP);
  assign snp_req_ready = snp_ready_reg;
  assign frame_err     = frame_err_reg;
  assign req_opcode    = req_opcode_reg;
  assign req_addr      = req_addr_reg;
  assign req_snoop     = req_snoop_reg;
  assign req_id        = req_id_reg;
  assign req_data      = req_data_reg;

endmodule

// File: tb/tb_outer_ebi_trx.sv
// Bench for outer_ebi_trx: host frames and backend responses built from the
// frame rules, with the bus looped back while the DUT drives it.
module tb_outer_ebi_trx;
  localparam int W  = 16;
  localparam int AW = 32;
  localparam int CL = 512;
  localparam int AC = AW / W;
  localparam int DC = CL / W;

  typedef logic [W-1:0] beat_q_t [$];

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [W-1:0]  host_drv = '1;
  logic [W-1:0]  ebi_i, ebi_o, ebi_oen;
  logic          req_valid, req_ready = 1'b0;
  logic [3:0]    req_opcode;
  logic [AW-1:0] req_addr;
  logic [W-1:0]  req_snoop, req_id;
  logic [CL-1:0] req_data;
  logic          rd_resp_valid = 1'b0, rd_resp_ready;
  logic [CL-1:0] rd_resp_data = '0;
  logic [W-1:0]  rd_resp_mesi = '0, rd_resp_id = '0;
  logic          snp_req_valid = 1'b0, snp_req_ready;
  logic [AW-1:0] snp_req_addr = '0;
  logic [W-1:0]  snp_req_snoop = '0;
  logic          frame_err;

  int n_vec = 0;
  int n_err = 0;
  int fe_cnt = 0;
  int rv_rise = 0;
  logic rv_prev = 1'b0;

  always #5 clk = ~clk;

  // Shared bus: the host drives unless the DUT has its output enabled.
  assign ebi_i = (ebi_oen == '1) ? host_drv : ebi_o;

  outer_ebi_trx dut (
    .clk(clk), .rst(rst), .ebi_i(ebi_i), .ebi_o(ebi_o), .ebi_oen(ebi_oen),
    .req_valid(req_valid), .req_ready(req_ready), .req_opcode(req_opcode),
    .req_addr(req_addr), .req_snoop(req_snoop), .req_id(req_id), .req_data(req_data),
    .rd_resp_valid(rd_resp_valid), .rd_resp_ready(rd_resp_ready),
    .rd_resp_data(rd_resp_data), .rd_resp_mesi(rd_resp_mesi), .rd_resp_id(rd_resp_id),
    .snp_req_valid(snp_req_valid), .snp_req_ready(snp_req_ready),
    .snp_req_addr(snp_req_addr), .snp_req_snoop(snp_req_snoop),
    .frame_err(frame_err)
  );

  // Count error pulses and request-valid rising edges away from the clock edge.
  always @(negedge clk) begin
    if (frame_err) fe_cnt <= fe_cnt + 1;
    if (req_valid && !rv_prev) rv_rise <= rv_rise + 1;
    rv_prev <= req_valid;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish, got running expected done");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [CL-1:0] obs, input logic [CL-1:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [CL-1:0] rand_line();
    logic [CL-1:0] r;
    for (int i = 0; i < CL / 32; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  function automatic beat_q_t host_frame(input logic [3:0] op, input logic [AW-1:0] addr,
                                         input logic [W-1:0] snoop, input logic [W-1:0] id,
                                         input logic [CL-1:0] data);
    beat_q_t q;
    q.push_back(16'hFFFE);
    q.push_back({12'h000, op});
    if (op <= 4'd2) begin
      for (int i = 0; i < AC; i++) q.push_back(addr[W*i +: W]);
      q.push_back(snoop);
    end
    if (op == 4'd0) q.push_back(id);
    if (op == 4'd1 || op == 4'd3) for (int i = 0; i < DC; i++) q.push_back(data[W*i +: W]);
    q.push_back(16'hFFFF);
    return q;
  endfunction

  function automatic beat_q_t rd_frame(input logic [CL-1:0] data, input logic [W-1:0] mesi,
                                       input logic [W-1:0] id);
    beat_q_t q;
    q.push_back(16'hFFFE);
    q.push_back(16'h0007);
    for (int i = 0; i < DC; i++) q.push_back(data[W*i +: W]);
    q.push_back(mesi);
    q.push_back(id);
    q.push_back(16'hFFFF);
    return q;
  endfunction

  function automatic beat_q_t snp_frame(input logic [AW-1:0] addr, input logic [W-1:0] snoop);
    beat_q_t q;
    q.push_back(16'hFFFE);
    q.push_back(16'h0006);
    for (int i = 0; i < AC; i++) q.push_back(addr[W*i +: W]);
    q.push_back(snoop);
    q.push_back(16'hFFFF);
    return q;
  endfunction

  function automatic beat_q_t ack_frame();
    beat_q_t q;
    q.push_back(16'hFFFE);
    q.push_back(16'hFFFF);
    return q;
  endfunction

  // Called on the cycle after a handshake: the start beat must already be out.
  task automatic cap_cmp(input string tag, input beat_q_t exp);
    beat_q_t got;
    int n = 0;
    chk({tag, "_start_oen"}, ebi_oen, 16'h0000);
    while (ebi_oen == 16'h0000 && n < 64) begin
      got.push_back(ebi_o);
      tick();
      n++;
    end
    chk({tag, "_len"}, got.size(), exp.size());
    for (int i = 0; i < exp.size() && i < got.size(); i++)
      chk($sformatf("%s_b%0d", tag, i), got[i], exp[i]);
    chk({tag, "_oen_release"}, ebi_oen, 16'hFFFF);
    chk({tag, "_o_release"}, ebi_o, 16'hFFFF);
  endtask

  task automatic chk_req(input string tag, input logic [3:0] op, input logic [AW-1:0] a,
                         input logic [W-1:0] s, input logic [W-1:0] id, input logic [CL-1:0] d);
    chk({tag, "_valid"}, req_valid, 1'b1);
    chk({tag, "_op"}, req_opcode, op);
    chk({tag, "_addr"}, req_addr, a);
    chk({tag, "_snoop"}, req_snoop, s);
    chk({tag, "_id"}, req_id, id);
    chk({tag, "_data"}, req_data, d);
  endtask

  task automatic snoop_txn(input logic [AW-1:0] addr, input logic [W-1:0] snoop);
    chk("snp_ready_idle", snp_req_ready, 1'b1);
    snp_req_addr  = addr;
    snp_req_snoop = snoop;
    snp_req_valid = 1'b1;
    tick();
    snp_req_valid = 1'b0;
    cap_cmp("snp", snp_frame(addr, snoop));
  endtask

  // One complete host transaction; optional colliding snoop and mid-TX reset.
  task automatic host_txn(input logic [3:0] op, input logic [AW-1:0] addr,
                          input logic [W-1:0] snoop, input logic [W-1:0] id,
                          input logic [CL-1:0] data, input int hold,
                          input logic [CL-1:0] r_data, input logic [W-1:0] r_mesi,
                          input logic [W-1:0] r_id, input bit collide,
                          input logic [AW-1:0] s_addr, input logic [W-1:0] s_snoop,
                          input int rst_at);
    beat_q_t q = host_frame(op, addr, snoop, id, data);
    beat_q_t rq;
    logic [AW-1:0] e_addr  = (op <= 4'd2) ? addr : '0;
    logic [W-1:0]  e_snoop = (op <= 4'd2) ? snoop : '0;
    logic [W-1:0]  e_id    = (op == 4'd0) ? id : '0;
    logic [CL-1:0] e_data  = (op == 4'd1 || op == 4'd3) ? data : '0;
    foreach (q[i]) begin
      host_drv = q[i];
      tick();
      if (i == 0 && collide) begin
        snp_req_addr  = s_addr;
        snp_req_snoop = s_snoop;
        snp_req_valid = 1'b1;
        chk("snp_ready_host_start", snp_req_ready, 1'b0);
      end
    end
    host_drv = '1;
    chk("rv_stop_plus1", req_valid, 1'b0);
    tick();
    chk_req("req", op, e_addr, e_snoop, e_id, e_data);
    for (int k = 0; k < hold; k++) begin
      tick();
      chk_req("req_hold", op, e_addr, e_snoop, e_id, e_data);
    end
    req_ready = 1'b1;
    tick();
    req_ready = 1'b0;
    chk("rv_after_hs", req_valid, 1'b0);
    if (op == 4'd0) begin
      chk("rd_resp_ready", rd_resp_ready, 1'b1);
      repeat ($urandom_range(0, 3)) tick();
      rd_resp_data  = r_data;
      rd_resp_mesi  = r_mesi;
      rd_resp_id    = r_id;
      rd_resp_valid = 1'b1;
      tick();
      rd_resp_valid = 1'b0;
      if (rst_at >= 0) begin
        rq = rd_frame(r_data, r_mesi, r_id);
        repeat (rst_at) tick();
        chk("pre_rst_beat", ebi_o, rq[rst_at]);
        rst = 1'b1;
        tick();
        chk("rst_oen", ebi_oen, 16'hFFFF);
        chk("rst_o", ebi_o, 16'hFFFF);
        chk("rst_rv", req_valid, 1'b0);
        chk("rst_rrdy", rd_resp_ready, 1'b0);
        chk("rst_op", req_opcode, 4'd0);
        chk("rst_addr", req_addr, 32'h0);
        rst = 1'b0;
        tick();
        tick();
        return;
      end
      cap_cmp("rd", rd_frame(r_data, r_mesi, r_id));
    end else begin
      cap_cmp("ack", ack_frame());
    end
    if (collide) begin
      chk("snp_ready_after", snp_req_ready, 1'b1);
      tick();
      snp_req_valid = 1'b0;
      cap_cmp("snp_late", snp_frame(s_addr, s_snoop));
    end
  endtask

  task automatic bad_op(input logic [3:0] op);
    int fe0 = fe_cnt;
    int rv0 = rv_rise;
    host_drv = 16'hFFFE;
    tick();
    host_drv = {12'h000, op};
    tick();
    host_drv = '1;
    chk("badop_fe_o1", frame_err, 1'b0);
    tick();
    chk("badop_fe_o2", frame_err, 1'b1);
    tick();
    chk("badop_fe_o3", frame_err, 1'b0);
    tick();
    chk("badop_idle", snp_req_ready, 1'b1);
    chk("badop_fe_count", fe_cnt - fe0, 1);
    chk("badop_no_rv", rv_rise - rv0, 0);
  endtask

  task automatic bad_stop(input logic [AW-1:0] addr, input logic [W-1:0] snoop,
                          input logic [W-1:0] stop);
    beat_q_t q = host_frame(4'd2, addr, snoop, '0, '0);
    int fe0 = fe_cnt;
    int rv0 = rv_rise;
    q[q.size() - 1] = stop;
    foreach (q[i]) begin
      host_drv = q[i];
      tick();
    end
    host_drv = '1;
    chk("badstop_fe_s1", frame_err, 1'b0);
    tick();
    chk("badstop_fe_s2", frame_err, 1'b1);
    tick();
    chk("badstop_fe_s3", frame_err, 1'b0);
    chk("badstop_rv", req_valid, 1'b0);
    tick();
    chk("badstop_idle", snp_req_ready, 1'b1);
    chk("badstop_fe_count", fe_cnt - fe0, 1);
    chk("badstop_no_rv", rv_rise - rv0, 0);
  endtask

  initial begin
    logic [CL-1:0] line;
    logic [3:0] op;
    int kind;

    // Reset values while rst is held.
    tick();
    tick();
    chk("rst_ebi_oen", ebi_oen, 16'hFFFF);
    chk("rst_ebi_o", ebi_o, 16'hFFFF);
    chk("rst_req_valid", req_valid, 1'b0);
    chk("rst_rd_resp_ready", rd_resp_ready, 1'b0);
    chk("rst_snp_req_ready", snp_req_ready, 1'b0);
    chk("rst_frame_err", frame_err, 1'b0);
    chk("rst_req_opcode", req_opcode, 4'd0);
    chk("rst_req_addr", req_addr, 32'h0);
    chk("rst_req_snoop", req_snoop, 16'h0);
    chk("rst_req_id", req_id, 16'h0);
    chk("rst_req_data", req_data, '0);
    rst = 1'b0;
    tick();
    tick();

    // DR with response beats 0..31, mesi 2, id 5.
    for (int i = 0; i < DC; i++) line[W*i +: W] = W'(i);
    host_txn(4'd0, 32'h80001234, 16'd3, 16'd5, '0, 0, line, 16'd2, 16'd5, 0, '0, '0, -1);

    // DW1 with data beats 0xA000+i.
    for (int i = 0; i < DC; i++) line[W*i +: W] = 16'hA000 + W'(i);
    host_txn(4'd1, 32'h00000100, 16'd0, 16'd0, line, 0, '0, '0, '0, 0, '0, '0, -1);

    // Snoop from idle, then one colliding with a host start.
    snoop_txn(32'hDEAD0040, 16'd1);
    host_txn(4'd2, 32'h12345678, 16'h0009, 16'd0, '0, 0, '0, '0, '0, 1, 32'hDEAD0040, 16'd1, -1);

    // Malformed frames.
    bad_op(4'd5);
    bad_op(4'($urandom_range(5, 15)));
    bad_stop(32'hCAFE0000, 16'h0004, 16'h1234);

    // Backpressure for 10 cycles.
    host_txn(4'd1, $urandom, 16'($urandom), 16'd0, rand_line(), 10, '0, '0, '0, 0, '0, '0, -1);

    // Reset at RD_RESP beat 10, then a clean DR.
    host_txn(4'd0, 32'h0BAD0BAD, 16'd1, 16'd7, '0, 0, rand_line(), 16'd1, 16'd7, 0, '0, '0, 10);
    host_txn(4'd0, 32'h00C0FFEE, 16'd2, 16'd9, '0, 1, rand_line(), 16'd3, 16'd9, 0, '0, '0, -1);

    // Randomised mix of all transaction kinds.
    for (int t = 0; t < 25; t++) begin
      kind = $urandom_range(0, 5);
      if (kind == 5) begin
        snoop_txn($urandom, 16'($urandom));
      end else begin
        op = 4'(kind);
        host_txn(op, $urandom, 16'($urandom), 16'($urandom), rand_line(),
                 $urandom_range(0, 3), rand_line(), 16'($urandom), 16'($urandom),
                 ($urandom_range(0, 3) == 0), $urandom, 16'($urandom), -1);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
